// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction side, immediate side and pipeline flush.
interface imm_gen_pipe_if #(parameter int XLEN = 32);
  logic            Flush;
  logic            InValid;
  logic            InReady;
  logic [24:0]     Instr;
  logic [2:0]      ImmSrc;
  logic            OutValid;
  logic            OutReady;
  logic [XLEN-1:0] ImmExt;
  logic            ImmIllegal;

  modport master (
    output Flush, InValid, Instr, ImmSrc, OutReady,
    input  InReady, OutValid, ImmExt, ImmIllegal
  );

  modport slave (
    input  Flush, InValid, Instr, ImmSrc, OutReady,
    output InReady, OutValid, ImmExt, ImmIllegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32I immediate generator with a 2-entry skid buffer (1-cycle latency, full throughput).
// Optional macro IMMGEN_CSR_ZIMM_EN enables ImmSrc=6 (CSR zimm, zero-extended Instr[19:15]).
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  imm_gen_pipe_if.slave bus
);

  logic            sgn;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  logic            main_v;
  logic [XLEN-1:0] main_imm;
  logic            main_ill;
  logic            skid_v;
  logic [XLEN-1:0] skid_imm;
  logic            skid_ill;

  logic            accept;
  logic            drain;

  // Instr holds instruction bits [31:7], so instruction bit k sits at index k-7.
  assign sgn = bus.Instr[24];

  always_comb begin
    imm32       = '0;
    dec_illegal = 1'b0;
    case (bus.ImmSrc)
      3'd0:    imm32 = {{20{sgn}}, bus.Instr[24:13]};
      3'd1:    imm32 = {{20{sgn}}, bus.Instr[24:18], bus.Instr[4:0]};
      3'd2:    imm32 = {{20{sgn}}, bus.Instr[0], bus.Instr[23:18], bus.Instr[4:1], 1'b0};
      3'd3:    imm32 = {bus.Instr[24:5], 12'b0};
      3'd4:    imm32 = {{12{sgn}}, bus.Instr[12:5], bus.Instr[13], bus.Instr[23:14], 1'b0};
`ifdef IMMGEN_CSR_ZIMM_EN
      3'd6:    imm32 = {27'b0, bus.Instr[12:8]};
`endif
      default: dec_illegal = 1'b1;
    endcase
  end

  // Bit 31 of imm32 is already the correct fill bit for every format, including zimm.
  assign dec_imm = XLEN'($signed(imm32));

  assign accept = bus.InValid & ~skid_v;
  assign drain  = main_v & bus.OutReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v   <= 1'b0;
      main_imm <= '0;
      main_ill <= 1'b0;
      skid_v   <= 1'b0;
      skid_imm <= '0;
      skid_ill <= 1'b0;
    end else if (bus.Flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (drain && skid_v) begin
      main_v   <= 1'b1;
      main_imm <= skid_imm;
      main_ill <= skid_ill;
      skid_v   <= 1'b0;
    end else if (accept && (!main_v || drain)) begin
      main_v   <= 1'b1;
      main_imm <= dec_imm;
      main_ill <= dec_illegal;
    end else if (accept) begin
      skid_v   <= 1'b1;
      skid_imm <= dec_imm;
      skid_ill <= dec_illegal;
    end else if (drain) begin
      main_v <= 1'b0;
    end
  end

  assign bus.InReady    = ~skid_v;
  assign bus.OutValid   = main_v;
  assign bus.ImmExt     = main_imm;
  assign bus.ImmIllegal = main_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=32 and XLEN=64 instances,
// then backpressure, flush and mid-stall reset sequences on the XLEN=32 instance.
module tb_imm_gen_pipe;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] exp_imm;
    logic        exp_ill;
  } vec_t;

  localparam int NVEC = 11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[NVEC];

  imm_gen_pipe_if #(.XLEN(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64)) bus64 ();

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [2:0] src);
    bus32.InValid = valid;
    bus32.Instr   = instr[31:7];
    bus32.ImmSrc  = src;
    bus64.InValid = valid;
    bus64.Instr   = instr[31:7];
    bus64.ImmSrc  = src;
  endtask

  task automatic checkOutput(input string name, input logic exp_valid, input logic chk_data,
                             input logic [31:0] exp_imm, input logic exp_ill, input logic exp_ready);
    checkValue({name, ".valid"}, {63'b0, bus32.OutValid}, {63'b0, exp_valid});
    checkValue({name, ".ready"}, {63'b0, bus32.InReady}, {63'b0, exp_ready});
    if (chk_data) begin
      checkValue({name, ".imm"}, {32'b0, bus32.ImmExt}, {32'b0, exp_imm});
      checkValue({name, ".ill"}, {63'b0, bus32.ImmIllegal}, {63'b0, exp_ill});
    end
  endtask

  task automatic checkOutput64(input string name, input logic [63:0] exp_imm, input logic exp_ill);
    checkValue({name, ".valid64"}, {63'b0, bus64.OutValid}, 64'd1);
    checkValue({name, ".imm64"}, bus64.ImmExt, exp_imm);
    checkValue({name, ".ill64"}, {63'b0, bus64.ImmIllegal}, {63'b0, exp_ill});
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{"i_neg1",  32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{"b_neg4",  32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0};
    vecs[2]  = '{"u_pos",   32'h123450B7, 3'd3, 32'h12345000, 1'b0};
    vecs[3]  = '{"s_neg8",  32'hFE112C23, 3'd1, 32'hFFFFFFF8, 1'b0};
    vecs[4]  = '{"j_pos8",  32'h008000EF, 3'd4, 32'h00000008, 1'b0};
    vecs[5]  = '{"j_neg4",  32'hFFDFF0EF, 3'd4, 32'hFFFFFFFC, 1'b0};
    vecs[6]  = '{"i_max",   32'h7FF00093, 3'd0, 32'h000007FF, 1'b0};
    vecs[7]  = '{"u_neg",   32'h800000B7, 3'd3, 32'h80000000, 1'b0};
    vecs[8]  = '{"src5",    32'h12345678, 3'd5, 32'h00000000, 1'b1};
    vecs[9]  = '{"src7",    32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b1};
`ifdef IMMGEN_CSR_ZIMM_EN
    vecs[10] = '{"zimm",    32'h340FD073, 3'd6, 32'h0000001F, 1'b0};
`else
    vecs[10] = '{"zimm",    32'h340FD073, 3'd6, 32'h00000000, 1'b1};
`endif

    rst = 1'b1;
    bus32.Flush = 1'b0;
    bus32.OutReady = 1'b1;
    bus64.Flush = 1'b0;
    bus64.OutReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 3'd0);

    tick();
    tick();
    checkOutput("reset", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    checkValue("reset.valid64", {63'b0, bus64.OutValid}, 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("post_reset", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);

    // Back-to-back stream: vector i-1 must be on the output in the cycle vector i is presented.
    for (int i = 0; i <= NVEC; i++) begin
      if (i < NVEC) applyStimulus(1'b1, vecs[i].instr, vecs[i].src);
      else applyStimulus(1'b0, 32'h0, 3'd0);
      tick();
      if (i < NVEC) begin
        checkOutput(vecs[i].name, 1'b1, 1'b1, vecs[i].exp_imm, vecs[i].exp_ill, 1'b1);
        checkOutput64(vecs[i].name, {{32{vecs[i].exp_imm[31]}}, vecs[i].exp_imm}, vecs[i].exp_ill);
      end
    end
    tick();
    checkOutput("stream_end", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Backpressure: A in main, B in skid, C held off until the skid empties.
    bus32.OutReady = 1'b0;
    applyStimulus(1'b1, 32'h7FF00093, 3'd0);
    tick();
    checkOutput("bp_a_main", 1'b1, 1'b1, 32'h000007FF, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hFE112C23, 3'd1);
    tick();
    checkOutput("bp_b_skid", 1'b1, 1'b1, 32'h000007FF, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h123450B7, 3'd3);
    tick();
    checkOutput("bp_stall1", 1'b1, 1'b1, 32'h000007FF, 1'b0, 1'b0);
    tick();
    checkOutput("bp_stall2", 1'b1, 1'b1, 32'h000007FF, 1'b0, 1'b0);
    bus32.OutReady = 1'b1;
    tick();
    checkOutput("bp_out_b", 1'b1, 1'b1, 32'hFFFFFFF8, 1'b0, 1'b1);
    tick();
    checkOutput("bp_out_c", 1'b1, 1'b1, 32'h12345000, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 3'd0);
    tick();
    checkOutput("bp_empty", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Flush with main and skid both full, input presented in the flush cycle.
    bus32.OutReady = 1'b0;
    applyStimulus(1'b1, 32'h7FF00093, 3'd0);
    tick();
    applyStimulus(1'b1, 32'hFE112C23, 3'd1);
    tick();
    checkOutput("fl_full", 1'b1, 1'b1, 32'h000007FF, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h800000B7, 3'd3);
    bus32.Flush = 1'b1;
    tick();
    checkOutput("fl_flushed", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    bus32.Flush = 1'b0;
    bus32.OutReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 3'd0);
    tick();
    checkOutput("fl_no_ghost", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Flush on an empty pipe must still discard the item presented alongside it.
    applyStimulus(1'b1, 32'hFFF00093, 3'd0);
    bus32.Flush = 1'b1;
    tick();
    checkOutput("fl_drop_in", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    bus32.Flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'd0);
    tick();
    checkOutput("fl_drop_after", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Reset while stalled with both entries full, Flush also asserted.
    bus32.OutReady = 1'b0;
    applyStimulus(1'b1, 32'hFFF00093, 3'd0);
    tick();
    applyStimulus(1'b1, 32'h12345678, 3'd7);
    tick();
    checkOutput("rs_full", 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    rst = 1'b1;
    bus32.Flush = 1'b1;
    applyStimulus(1'b0, 32'h0, 3'd0);
    tick();
    rst = 1'b0;
    bus32.Flush = 1'b0;
    checkOutput("rs_cleared", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    bus32.OutReady = 1'b1;
    tick();
    checkOutput("rs_no_ghost", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
